// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Definitions shared across the MIPS datapath blocks: the
//                datapath word width, the channel ceiling for mux_pipe and
//                the mux_pipe occupancy state encoding.
//  Revision    : 1.0  - initial release
// ============================================================================
package mips_pkg;

    // Native word width of the datapath.
    localparam int WORD_W     = 32;

    // Largest channel count mux_pipe is qualified for.
    localparam int MUX_MAX_IN = 16;

    // Occupancy of mux_pipe. ST_ONE doubles as "FULL" when there is no skid
    // buffer. ST_TWO is reachable only when the skid buffer is built in.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } mux_state_t;

endpackage
`default_nettype wire

// File: rtl/mux_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : mux_pipe_if
//  Description : Handshake and data bundle for mux_pipe.
//                master modport : the upstream/downstream environment
//                slave  modport : the mux_pipe block
//  Signals     : in_valid/in_ready   upstream handshake
//                sel [SEL_W]         channel select
//                in_data [NUM_IN*WIDTH] flattened channels; channel k is
//                                    in_data[k*WIDTH +: WIDTH]
//                out_valid/out_ready downstream handshake
//                out_data [WIDTH]    selected channel, registered
//                sel_err             out-of-range select flag for this beat
//  Revision    : 1.0  - initial release
// ============================================================================
interface mux_pipe_if
    import mips_pkg::*;
#(
    parameter int WIDTH  = WORD_W,
    parameter int NUM_IN = 4
);
    localparam int SEL_W = $clog2(NUM_IN);

    logic                    in_valid;
    logic                    in_ready;
    logic [SEL_W-1:0]        sel;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    sel_err;

    modport master (
        output in_valid,
        output sel,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  sel_err
    );

    modport slave (
        input  in_valid,
        input  sel,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output sel_err
    );

endinterface
`default_nettype wire

// File: rtl/mux_sel_comb.sv
`default_nettype none
// ============================================================================
//  Module      : mux_sel_comb
//  Description : Purely combinational N-way, W-bit selector with
//                out-of-range detection. An out-of-range select yields an
//                all-zero word with o_err set.
//  Ports       : i_sel  [SEL_W]         channel select
//                i_data [NUM_IN*WIDTH]  flattened channels
//                o_data [WIDTH]         selected channel (0 when out of range)
//                o_err                  select >= NUM_IN
//  Revision    : 1.0  - initial release
// ============================================================================
module mux_sel_comb
    import mips_pkg::*;
#(
    parameter int WIDTH  = WORD_W,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  wire logic [SEL_W-1:0]        i_sel,
    input  wire logic [NUM_IN*WIDTH-1:0] i_data,
    output logic      [WIDTH-1:0]        o_data,
    output logic                         o_err
);

    logic [WIDTH-1:0] w_data;
    logic             w_err;

    // Start from the out-of-range result; a matching channel overrides it.
    // With NUM_IN a power of two every code matches and w_err never survives.
    always_comb begin
        w_data = '0;
        w_err  = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (i_sel == SEL_W'(k)) begin
                w_data = i_data[k*WIDTH +: WIDTH];
                w_err  = 1'b0;
            end
        end
    end

    assign o_data = w_data;
    assign o_err  = w_err;

endmodule
`default_nettype wire

// File: rtl/mux_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : mux_pipe
//  Description : Parametrised N-way, W-bit selector with a registered output
//                stage and valid/ready handshake. Select and data are captured
//                together on the accept edge. Latency accept->out_valid is 1.
//  Ports       : clk            system clock, rising edge
//                rst            synchronous active-high reset
//                bus (slave)    in_valid, in_ready, sel, in_data,
//                               out_valid, out_ready, out_data, sel_err
//  Parameters  : WIDTH  (default WORD_W = 32) channel / output width
//                NUM_IN (default 4, range 2..MUX_MAX_IN) channel count
//  Options     : MUX_PIPE_SKID_EN - when defined, a second (skid) entry is
//                added and in_ready becomes a registered output
//                (EMPTY/ONE/TWO). When undefined, one output register and a
//                combinational in_ready = !out_valid || out_ready.
//  Revision    : 1.0  - initial release
// ============================================================================
module mux_pipe
    import mips_pkg::*;
#(
    parameter int WIDTH  = WORD_W,
    parameter int NUM_IN = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    mux_pipe_if.slave bus
);

    localparam int SEL_W = $clog2(NUM_IN);

    // ------------------------------------------------------------------
    // Selector: one instance feeds both the output and skid registers.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_sel_data;
    logic             w_sel_err;

    mux_sel_comb #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_sel (
        .i_sel  (bus.sel),
        .i_data (bus.in_data),
        .o_data (w_sel_data),
        .o_err  (w_sel_err)
    );

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    mux_state_t       r_state;
    mux_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_data;
    logic             r_err;

    logic w_out_valid;
    logic w_in_ready;
    logic w_accept;
    logic w_drain;
    logic w_load_out;

    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_drain     = w_out_valid && bus.out_ready;

`ifdef MUX_PIPE_SKID_EN
    logic [WIDTH-1:0] r_skid_data;
    logic             r_skid_err;
    logic             r_in_ready;
    logic             w_load_skid;
    logic             w_skid_to_out;

    // Registered ready: it only depends on whether the skid slot will be
    // occupied after this edge, so it never combinationally follows out_ready.
    assign w_in_ready = r_in_ready;
`else
    // Ready whenever the output register is empty or is being emptied now.
    assign w_in_ready = !w_out_valid || bus.out_ready;
`endif

    // ------------------------------------------------------------------
    // Next-state / load control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_load_out  = 1'b0;
`ifdef MUX_PIPE_SKID_EN
        w_load_skid   = 1'b0;
        w_skid_to_out = 1'b0;
`endif
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ST_ONE;
                    w_load_out  = 1'b1;
                end
            end
            ST_ONE: begin
`ifdef MUX_PIPE_SKID_EN
                if (w_accept && w_drain) begin
                    w_load_out = 1'b1;
                end else if (w_accept) begin
                    // Output is stalled: park the new beat behind it.
                    w_state_nxt = ST_TWO;
                    w_load_skid = 1'b1;
                end else if (w_drain) begin
                    w_state_nxt = ST_EMPTY;
                end
`else
                if (w_accept) begin
                    // Drain and accept on the same edge: replace, no bubble.
                    w_load_out = 1'b1;
                end else if (w_drain) begin
                    w_state_nxt = ST_EMPTY;
                end
`endif
            end
`ifdef MUX_PIPE_SKID_EN
            ST_TWO: begin
                // in_ready is low here, so only the skid entry can move.
                if (w_drain) begin
                    w_state_nxt   = ST_ONE;
                    w_skid_to_out = 1'b1;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_err  <= 1'b0;
        end else if (w_load_out) begin
            r_data <= w_sel_data;
            r_err  <= w_sel_err;
`ifdef MUX_PIPE_SKID_EN
        end else if (w_skid_to_out) begin
            r_data <= r_skid_data;
            r_err  <= r_skid_err;
`endif
        end
    end

`ifdef MUX_PIPE_SKID_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_skid_data <= '0;
            r_skid_err  <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            if (w_load_skid) begin
                r_skid_data <= w_sel_data;
                r_skid_err  <= w_sel_err;
            end
            r_in_ready <= (w_state_nxt != ST_TWO);
        end
    end
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = r_data;
    assign bus.sel_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mux_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_pipe
//  Description : Self-checking bench for mux_pipe. A 4-channel instance is
//                tracked by a scoreboard (expected beats queued on accept,
//                compared on drain); a 3-channel instance exercises the
//                out-of-range select path. Works with or without
//                MUX_PIPE_SKID_EN.
//  Revision    : 1.0  - initial release
// ============================================================================
module tb_mux_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mux_pipe_if #(.WIDTH(32), .NUM_IN(4)) b4 ();
    mux_pipe_if #(.WIDTH(32), .NUM_IN(3)) b3 ();

    mux_pipe #(.WIDTH(32), .NUM_IN(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (b4)
    );

    mux_pipe #(.WIDTH(32), .NUM_IN(3)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (b3)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_acc   = 0;

    logic [32:0] sb_q[$];

    localparam logic [127:0] c_DATA4 = {32'h0000ffff, 32'hffff0000, 32'h12345678, 32'hdeadbeef};
    localparam logic [95:0]  c_DATA3 = {32'hffff0000, 32'h12345678, 32'hdeadbeef};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected {err, data} for a beat accepted with select s over n channels.
    function automatic logic [32:0] model(input int n, input logic [1:0] s, input logic [127:0] d);
        if (int'(s) >= n) return {1'b1, 32'h0};
        return {1'b0, d[s*32 +: 32]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor for the 4-channel instance. Inputs change 1 time
    // unit after the rising edge, so at the falling edge both the inputs and
    // the registered outputs are stable and describe the coming edge.
    always @(negedge clk) begin
        logic [32:0] e;
        if (rst) begin
            sb_q.delete();
        end else begin
            if (!b4.out_valid) chk("rdy_when_empty", {63'd0, b4.in_ready}, 64'd1);
            if (b4.out_valid && b4.out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_data", {32'd0, b4.out_data}, {32'd0, e[31:0]});
                    chk("sb_err",  {63'd0, b4.sel_err},  {63'd0, e[32]});
                end
            end
            if (b4.in_valid && b4.in_ready) begin
                sb_q.push_back(model(4, b4.sel, b4.in_data));
                n_acc++;
            end
        end
    end

    initial begin
        logic [31:0] exp_sel [4];
        int          start_acc;
        int          cyc;

        exp_sel[0] = 32'hdeadbeef;
        exp_sel[1] = 32'h12345678;
        exp_sel[2] = 32'hffff0000;
        exp_sel[3] = 32'h0000ffff;

        // ---------------- reset with in_valid high ----------------
        b4.in_valid = 1'b1; b4.sel = 2'd0; b4.in_data = c_DATA4; b4.out_ready = 1'b1;
        b3.in_valid = 1'b1; b3.sel = 2'd0; b3.in_data = c_DATA3; b3.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) step();
        chk("rst_out_valid", {63'd0, b4.out_valid}, 64'd0);
        chk("rst_out_data",  {32'd0, b4.out_data},  64'd0);
        chk("rst_sel_err",   {63'd0, b4.sel_err},   64'd0);
        chk("rst_in_ready",  {63'd0, b4.in_ready},  64'd1);
        chk("rst3_out_valid", {63'd0, b3.out_valid}, 64'd0);
        rst = 1'b0;
        b4.in_valid = 1'b0;
        b3.in_valid = 1'b0;
        step();

        // ---------------- basic select, back to back ----------------
        for (int s = 0; s < 4; s++) begin
            b4.in_valid = 1'b1;
            b4.sel      = 2'(s);
            step();
            chk("basic_valid", {63'd0, b4.out_valid}, 64'd1);
            chk("basic_data",  {32'd0, b4.out_data},  {32'd0, exp_sel[s]});
        end
        b4.in_valid = 1'b0;
        step();
        chk("basic_drained", {63'd0, b4.out_valid}, 64'd0);

        // ---------------- stall hold ----------------
        b4.in_valid = 1'b1; b4.sel = 2'd1; b4.out_ready = 1'b0;
        step();
        chk("stall_first", {32'd0, b4.out_data}, 64'h12345678);
        for (int i = 0; i < 5; i++) begin
            b4.sel     = 2'($urandom_range(0, 3));
            b4.in_data = {$urandom, $urandom, $urandom, $urandom};
            step();
            chk("stall_data",  {32'd0, b4.out_data},  64'h12345678);
            chk("stall_valid", {63'd0, b4.out_valid}, 64'd1);
            chk("stall_ready", {63'd0, b4.in_ready},  64'd0);
        end
        b4.in_valid = 1'b0; b4.out_ready = 1'b1; b4.in_data = c_DATA4;
        repeat (3) step();
        chk("stall_released", {63'd0, b4.out_valid}, 64'd0);

        // ---------------- out-of-range select (3 channels) ----------------
        b3.in_valid = 1'b1; b3.sel = 2'd3; b3.out_ready = 1'b1;
        step();
        chk("oor_data",  {32'd0, b3.out_data}, 64'd0);
        chk("oor_err",   {63'd0, b3.sel_err},  64'd1);
        chk("oor_valid", {63'd0, b3.out_valid}, 64'd1);
        b3.sel = 2'd0;
        step();
        chk("oor_clear_data", {32'd0, b3.out_data}, 64'hdeadbeef);
        chk("oor_clear_err",  {63'd0, b3.sel_err},  64'd0);
        b3.sel = 2'd2;
        step();
        chk("oor_ch2", {32'd0, b3.out_data}, 64'hffff0000);
        // error flag held through a stall
        b3.sel = 2'd3;
        step();
        b3.out_ready = 1'b0; b3.sel = 2'd0;
        repeat (2) step();
        chk("oor_stall_err",  {63'd0, b3.sel_err},  64'd1);
        chk("oor_stall_data", {32'd0, b3.out_data}, 64'd0);
        b3.in_valid = 1'b0; b3.out_ready = 1'b1;
        repeat (3) step();
        chk("oor_drained", {63'd0, b3.out_valid}, 64'd0);

        // ---------------- mid-operation reset ----------------
        b4.in_valid = 1'b1; b4.sel = 2'd2; b4.out_ready = 1'b0;
        step();
        b4.sel = 2'd3;
        step();
        rst = 1'b1;
        step();
        chk("mrst_valid", {63'd0, b4.out_valid}, 64'd0);
        chk("mrst_data",  {32'd0, b4.out_data},  64'd0);
        chk("mrst_ready", {63'd0, b4.in_ready},  64'd1);
        rst = 1'b0; b4.sel = 2'd1; b4.out_ready = 1'b1;
        step();
        chk("mrst_first_valid", {63'd0, b4.out_valid}, 64'd1);
        chk("mrst_first_data",  {32'd0, b4.out_data},  64'h12345678);
        b4.in_valid = 1'b0;
        repeat (2) step();

        // ---------------- random throughput ----------------
        start_acc = n_acc;
        cyc = 0;
        while ((n_acc - start_acc) < 1000 && cyc < 20000) begin
            b4.in_valid  = ($urandom_range(0, 3) != 0);
            b4.out_ready = ($urandom_range(0, 9) < 7);
            b4.sel       = 2'($urandom_range(0, 3));
            b4.in_data   = {$urandom, $urandom, $urandom, $urandom};
            step();
            cyc++;
        end
        chk("rand_budget", {63'd0, ((n_acc - start_acc) >= 1000)}, 64'd1);
        b4.in_valid = 1'b0; b4.out_ready = 1'b1;
        repeat (5) step();
        chk("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux_pipe.md
Name: mux_pipe

Overview:
- Parametrised N-way, W-bit selector with a registered output stage and valid/ready handshake.
- Successor to the fixed 2:1 32-bit combinational mux on the MIPS datapath.
- Used where a mux result must be pipelined: writeback select, ALU operand forwarding, PC-source select.
- Select is captured together with the data, so each output beat reflects the inputs and select present on its accept cycle.

Parameters:
- WIDTH, 32, bit width of each input channel and of the output.
- NUM_IN, 4, number of input channels; legal range 2..16.
- SEL_W, $clog2(NUM_IN), width of the select field; derived, not overridden.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- sel  in  SEL_W  channel select; sampled only on accept.
- in_data  in  NUM_IN*WIDTH  flattened inputs; channel k occupies bits [k*WIDTH +: WIDTH].
- out_valid  out  1  out_data holds a valid beat.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  WIDTH  selected channel, registered.
- sel_err  out  1  current output beat came from an out-of-range select.

Behaviour:
- Reset: when rst is sampled high at a clock edge, all outputs reset on that edge.
  - out_valid=0, out_data=0, sel_err=0.
  - in_ready=1 after reset.
  - Any in-flight beat is discarded.
- Accept: occurs when in_valid && in_ready at a rising edge.
  - out_data <= channel[sel]; out_valid <= 1.
  - Latency is 1 cycle from accept to out_valid.
- Drain: occurs when out_valid && out_ready; out_valid falls unless a new beat is accepted on the same edge.
- Base mode (no skid):
  - in_ready = !out_valid || out_ready (combinational).
  - Simultaneous drain and accept on the same edge gives full throughput: the new beat replaces the old one, with no bubble.
- Stall: while out_valid && !out_ready, out_data, sel_err and out_valid hold stable. Changes on sel or in_data are ignored.
- Out-of-range select (sel >= NUM_IN, possible when NUM_IN is not a power of 2):
  - out_data <= 0 and sel_err <= 1 for that beat.
  - The beat is otherwise handled normally.
  - sel_err is cleared by the next accepted in-range beat.
- in_valid=0 causes no state change except a drain.
- State machine (base mode): EMPTY <-> FULL, tracked by out_valid.
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on drain without accept.
  - FULL -> FULL on drain with accept, or on stall.

Optional Feature:
- Macro MUX_PIPE_SKID_EN.
- Defined: a 2-entry skid buffer is added and in_ready becomes a registered output.
  - States: EMPTY, ONE, TWO.
  - in_ready = (state != TWO), registered.
  - A beat accepted while the output stalls goes into the skid register.
  - When out_ready returns, the skid entry moves to the output on the next edge.
  - Order is preserved; full throughput is kept.
  - Reset clears both entries and sets the state to EMPTY.
- Undefined: single output register with combinational in_ready, as described under Behaviour.

Decomposition:
- Shared package mips_pkg holds:
  - the mux_pipe state enum (EMPTY, ONE, TWO);
  - the localparam MUX_MAX_IN = 16;
  - the width constant WORD_W = 32 shared with the datapath.
- One sub-module, mux_sel_comb: purely combinational N-way select with out-of-range detect.
  - Output is the zeroed data plus an err bit.
  - Instantiated once, feeding the output and skid registers.

Test Plan:
- Reset: hold rst=1 for 3 cycles with in_valid=1 -> out_valid=0, out_data=0, sel_err=0; in_ready=1 after reset.
- Basic select: WIDTH=32, NUM_IN=4, in_data = {32'h0000ffff, 32'hffff0000, 32'h12345678, 32'hdeadbeef}, out_ready=1; sel steps 0,1,2,3 on back-to-back cycles -> out_data is 32'hdeadbeef, 32'h12345678, 32'hffff0000, 32'h0000ffff, one cycle after each accept, with no bubbles.
- Stall hold: accept sel=1, hold out_ready=0 for 5 cycles while changing sel and in_data -> out_data stays 32'h12345678 and no further accept occurs (base mode); one beat enters skid, then in_ready=0 (skid mode). On release, beats emerge in order.
- Out-of-range: NUM_IN=3, sel=3 -> out_data=0 and sel_err=1; next beat with sel=0 -> sel_err=0.
- Mid-operation reset: FULL and stalled, assert rst for 1 cycle -> out_valid=0 on the next edge, skid entry discarded, and the first beat after reset is the next accepted input.
- Random throughput: 1000 beats with random in_valid/out_ready -> scoreboard shows no loss, duplication or reordering, and in_ready never deasserts while the block is empty.
